mips_multicycle_control: RTL and testbench
==========================================

Name: mips_multicycle_control

Overview:
Main control FSM for the multicycle MIPS datapath. It decodes the instruction opcode and sequences the fetch, decode, execute, memory and writeback steps. It produces the 2-bit ALU_Op consumed by the downstream ALU function decoder, plus all datapath mux selects and write enables. It also handshakes with a variable-latency unified memory and flags memory timeouts.

Parameters:
MEM_TIMEOUT, 16, number of cycles to wait for Mem_Ready in a memory state before aborting; 0 disables the timeout.
CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
Op  input  6  instruction opcode, Instr[31:26], valid from DECODE onward
Zero  input  1  ALU zero flag
Mem_Ready  input  1  memory completed the current access this cycle
Mem_Req  output  1  memory access request
IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
MemWrite  output  1  memory write enable
IRWrite  output  1  instruction register load
RegDst  output  1  register destination: 0 = rt, 1 = rd
MemtoReg  output  1  register write data: 0 = ALUOut, 1 = Data
RegWrite  output  1  register file write enable
ALUSrcA  output  1  ALU A input: 0 = PC, 1 = A
ALUSrcB  output  2  ALU B input: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
ALU_Op  output  2  00 = add, 01 = sub, 10 = R-type (use funct)
PCSrc  output  2  PC source: 00 = ALUResult, 01 = ALUOut, 10 = jump target
PCEn  output  1  PC load, equal to PCWrite | (Branch & Zero)
Illegal_Op  output  1  one-cycle pulse on an unsupported opcode
Mem_Err  output  1  sticky memory timeout flag
State  output  4  current state encoding, for debug

Behaviour:
- Opcodes: R-type 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11.
- Outputs are Moore functions of the state, except for the Mem_Ready and Zero gating noted below. Any output not listed for a state is 0.
- FETCH: Mem_Req=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALU_Op=00, PCSrc=00.
  - IRWrite and PCWrite equal Mem_Ready.
  - Stays in FETCH until Mem_Ready=1, then goes to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALU_Op=00 (branch target computed into ALUOut).
  - Next state by opcode: LW or SW go to MEMADR; R-type to EXECUTE; BEQ to BRANCH; ADDI to ADDIEXEC; J to JUMP.
  - Any other opcode: Illegal_Op=1 for this cycle, next state FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALU_Op=00. Next state is MEMRD for LW, MEMWR for SW.
- MEMRD: Mem_Req=1, IorD=1. Waits for Mem_Ready, then goes to MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Next state FETCH.
- MEMWR: Mem_Req=1, IorD=1, MemWrite=1. Waits for Mem_Ready, then goes to FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALU_Op=10. Next state ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1. Next state FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALU_Op=01, PCSrc=01, Branch=1. PCEn=Zero. Next state FETCH.
- ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ALU_Op=00. Next state ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1. Next state FETCH.
- JUMP: PCSrc=10, PCWrite=1. Next state FETCH.
- Timeout counter:
  - Clears on entry to FETCH, MEMRD or MEMWR.
  - Increments on each cycle spent in one of those states with Mem_Ready=0.
  - When the count reaches MEM_TIMEOUT with Mem_Ready still 0 (and MEM_TIMEOUT is not 0): set Mem_Err, force next state to FETCH, and assert no write enable that cycle.
  - Mem_Err stays set until rst.
- Mem_Ready in a non-memory state is ignored.
- Reset:
  - While rst=1, the state register loads FETCH, the counter and Mem_Err load 0.
  - While rst=1, all enables are forced to 0: Mem_Req, MemWrite, IRWrite, RegWrite, PCEn, Illegal_Op.
  - After rst falls, the first cycle is FETCH with Mem_Req=1.
  - Reset asserted mid-instruction (e.g. in MEMWR) aborts the instruction; no write occurs on or after the reset cycle.
- Instruction latency with zero memory wait: LW 5 cycles; SW, R-type and ADDI 4; BEQ and J 3. Each memory state adds one cycle per Mem_Ready=0 cycle.

Test Plan:
- Reset, then Mem_Ready tied to 1, Op=000000 -> states 0,1,6,7,0; ALU_Op=10 in EXECUTE; RegWrite=1 and RegDst=1 only in ALUWB.
- Op=100011 with Mem_Ready=0 for 3 cycles in MEMRD -> states 0,1,2,3,3,3,3,4,0; RegWrite=1 and MemtoReg=1 in MEMWB only.
- Op=000100: Zero=1 gives PCEn=1 in BRANCH with ALU_Op=01 and PCSrc=01; repeating with Zero=0 gives PCEn=0.
- Op=111111 -> Illegal_Op pulses for exactly 1 cycle in DECODE; next state FETCH; no RegWrite or MemWrite.
- MEM_TIMEOUT=4, Op=101011, Mem_Ready held 0 in MEMWR -> after 4 cycles Mem_Err=1, state returns to FETCH; Mem_Err stays 1 until rst.
- rst asserted while in MEMWR with Mem_Ready=1 -> MemWrite=0 that cycle; next state FETCH; Mem_Err=0.

Source files
------------

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback and drives the datapath
// selects and write enables. It also waits on a variable-latency memory and
// aborts to FETCH with a sticky error if an access takes too long.
module mips_multicycle_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Op,
  input  logic       Zero,
  input  logic       Mem_Ready,
  output logic       Mem_Req,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALU_Op,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       Illegal_Op,
  output logic       Mem_Err,
  output logic [3:0] State
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMRD    = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWR    = 4'd5;
  localparam logic [3:0] S_EXECUTE  = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_ADDIEXEC = 4'd9;
  localparam logic [3:0] S_ADDIWB   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Counter value seen on the last tolerated wait cycle; only used when
  // the timeout is enabled.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(MEM_TIMEOUT - 1);

  logic [3:0]       r_state;
  logic [3:0]       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_mem_err;

  logic w_mem_state;
  logic w_timeout;
  logic w_mem_req;
  logic w_mem_write;
  logic w_ir_write;
  logic w_reg_write;
  logic w_pc_write;
  logic w_branch;
  logic w_illegal;

  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  assign w_timeout   = (MEM_TIMEOUT != 0) && w_mem_state && !Mem_Ready && (r_cnt == TO_LAST);

  // Moore decode of the current state plus next-state selection.
  always_comb begin
    w_state_next = S_FETCH;
    w_mem_req    = 1'b0;
    IorD         = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    RegDst       = 1'b0;
    MemtoReg     = 1'b0;
    w_reg_write  = 1'b0;
    ALUSrcA      = 1'b0;
    ALUSrcB      = 2'b00;
    ALU_Op       = 2'b00;
    PCSrc        = 2'b00;
    w_pc_write   = 1'b0;
    w_branch     = 1'b0;
    w_illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_req    = 1'b1;
        ALUSrcB      = 2'b01;
        w_ir_write   = Mem_Ready;
        w_pc_write   = Mem_Ready;
        w_state_next = Mem_Ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (Op)
          OP_LW, OP_SW: w_state_next = S_MEMADR;
          OP_RTYPE:     w_state_next = S_EXECUTE;
          OP_BEQ:       w_state_next = S_BRANCH;
          OP_ADDI:      w_state_next = S_ADDIEXEC;
          OP_J:         w_state_next = S_JUMP;
          default: begin
            w_illegal    = 1'b1;
            w_state_next = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA      = 1'b1;
        ALUSrcB      = 2'b10;
        w_state_next = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        w_mem_req    = 1'b1;
        IorD         = 1'b1;
        w_state_next = Mem_Ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        MemtoReg    = 1'b1;
        w_reg_write = 1'b1;
      end
      S_MEMWR: begin
        w_mem_req    = 1'b1;
        IorD         = 1'b1;
        w_mem_write  = 1'b1;
        w_state_next = Mem_Ready ? S_FETCH : S_MEMWR;
      end
      S_EXECUTE: begin
        ALUSrcA      = 1'b1;
        ALU_Op       = 2'b10;
        w_state_next = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst      = 1'b1;
        w_reg_write = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALU_Op   = 2'b01;
        PCSrc    = 2'b01;
        w_branch = 1'b1;
      end
      S_ADDIEXEC: begin
        ALUSrcA      = 1'b1;
        ALUSrcB      = 2'b10;
        w_state_next = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_reg_write = 1'b1;
      end
      S_JUMP: begin
        PCSrc      = 2'b10;
        w_pc_write = 1'b1;
      end
      default: w_state_next = S_FETCH;
    endcase
    if (w_timeout) begin
      w_state_next = S_FETCH;
    end
  end

  // Wait counter restarts on every state change (including a timeout
  // re-entry into FETCH) and counts cycles spent waiting on memory.
  always_comb begin
    w_cnt_next = r_cnt;
    if (w_timeout || (w_state_next != r_state)) begin
      w_cnt_next = '0;
    end else if (w_mem_state && !Mem_Ready) begin
      w_cnt_next = r_cnt + CNT_W'(1);
    end
  end

  // State, wait counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_cnt     <= '0;
      r_mem_err <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_mem_err <= r_mem_err | w_timeout;
    end
  end

  // Enables are suppressed during reset, and writes are suppressed on the
  // cycle a memory access is abandoned.
  assign Mem_Req    = w_mem_req & ~rst;
  assign MemWrite   = w_mem_write & ~w_timeout & ~rst;
  assign IRWrite    = w_ir_write & ~w_timeout & ~rst;
  assign RegWrite   = w_reg_write & ~rst;
  assign PCEn       = (w_pc_write | (w_branch & Zero)) & ~w_timeout & ~rst;
  assign Illegal_Op = w_illegal & ~rst;
  assign Mem_Err    = r_mem_err;
  assign State      = r_state;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: a directed vector table walking the
// listed instruction sequences, then randomized traffic checked against an
// instruction-level model (state paths per opcode + per-state output table).
module tb_mips_multicycle_control;

  localparam int TO = 4;

  localparam logic [5:0] R    = 6'b000000;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] J    = 6'b000010;
  localparam logic [5:0] BAD  = 6'b111111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] Op = 6'd0;
  logic       Zero = 1'b0;
  logic       Mem_Ready = 1'b0;
  logic       Mem_Req, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALU_Op, PCSrc;
  logic       PCEn, Illegal_Op, Mem_Err;
  logic [3:0] State;

  always #5 clk = ~clk;

  mips_multicycle_control #(.MEM_TIMEOUT(TO), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .Op(Op), .Zero(Zero), .Mem_Ready(Mem_Ready),
    .Mem_Req(Mem_Req), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALU_Op(ALU_Op), .PCSrc(PCSrc), .PCEn(PCEn),
    .Illegal_Op(Illegal_Op), .Mem_Err(Mem_Err), .State(State)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       zero;
    logic       rdy;
    logic [3:0] st;
    logic       mreq;
    logic [1:0] aluop;
    logic       regwr, regdst, mtr, memwr, pcen, ill, err;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic r, input logic [5:0] op, input logic z, input logic rdy,
                     input logic [3:0] st, input logic mreq, input logic [1:0] aluop,
                     input logic regwr, input logic regdst, input logic mtr,
                     input logic memwr, input logic pcen, input logic ill, input logic err);
    vec_t v;
    v.rst = r; v.op = op; v.zero = z; v.rdy = rdy; v.st = st; v.mreq = mreq;
    v.aluop = aluop; v.regwr = regwr; v.regdst = regdst; v.mtr = mtr;
    v.memwr = memwr; v.pcen = pcen; v.ill = ill; v.err = err;
    vt.push_back(v);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [3:0] st;
    logic       mreq, iord, memwr, irwr, regdst, mtr, regwr, srca;
    logic [1:0] srcb, aluop, pcsrc;
    logic       pcen, ill, err;
  } obs_t;

  // Per-state control settings; irrdy/pcwr in FETCH only take effect with Mem_Ready.
  typedef struct packed {
    logic       mreq, iord, memwr, irrdy, regdst, mtr, regwr, srca;
    logic [1:0] srcb, aluop, pcsrc;
    logic       pcwr, br;
  } row_t;

  row_t tab[12];
  int   m_state;
  int   m_waits;
  logic m_err;
  int   m_path[$];

  function automatic bit is_legal(input logic [5:0] op);
    return (op == R) || (op == LW) || (op == SW) || (op == BEQ) || (op == ADDI) || (op == J);
  endfunction

  function automatic bit is_mem(input int s);
    return (s == 0) || (s == 3) || (s == 5);
  endfunction

  // States visited after a completed fetch, for a given opcode.
  function automatic void load_path(input logic [5:0] op);
    m_path.delete();
    m_path.push_back(1);
    case (op)
      R:    begin m_path.push_back(6); m_path.push_back(7); end
      LW:   begin m_path.push_back(2); m_path.push_back(3); m_path.push_back(4); end
      SW:   begin m_path.push_back(2); m_path.push_back(5); end
      BEQ:  m_path.push_back(8);
      ADDI: begin m_path.push_back(9); m_path.push_back(10); end
      J:    m_path.push_back(11);
      default: ;
    endcase
  endfunction

  function automatic obs_t sample_obs();
    obs_t o;
    o.st = State; o.mreq = Mem_Req; o.iord = IorD; o.memwr = MemWrite; o.irwr = IRWrite;
    o.regdst = RegDst; o.mtr = MemtoReg; o.regwr = RegWrite; o.srca = ALUSrcA;
    o.srcb = ALUSrcB; o.aluop = ALU_Op; o.pcsrc = PCSrc; o.pcen = PCEn;
    o.ill = Illegal_Op; o.err = Mem_Err;
    return o;
  endfunction

  // Expected outputs this cycle, then advance the model by one clock.
  task automatic model_cycle(input logic r, input logic [5:0] op, input logic z,
                             input logic rdy, output obs_t e);
    row_t t;
    bit   to;
    bit   pcw;
    t   = tab[m_state];
    to  = (TO != 0) && is_mem(m_state) && !rdy && (m_waits + 1 == TO);
    pcw = t.pcwr && ((m_state == 0) ? rdy : 1'b1);
    e.st = 4'(m_state);
    e.mreq = t.mreq & !r;
    e.iord = t.iord;
    e.memwr = t.memwr & !to & !r;
    e.irwr = t.irrdy & rdy & !to & !r;
    e.regdst = t.regdst;
    e.mtr = t.mtr;
    e.regwr = t.regwr & !r;
    e.srca = t.srca;
    e.srcb = t.srcb;
    e.aluop = t.aluop;
    e.pcsrc = t.pcsrc;
    e.pcen = (pcw | (t.br & z)) & !to & !r;
    e.ill = (m_state == 1) && !is_legal(op) && !r;
    e.err = m_err;
    if (r) begin
      m_state = 0; m_waits = 0; m_err = 1'b0; m_path.delete();
    end else if (to) begin
      m_state = 0; m_waits = 0; m_err = 1'b1; m_path.delete();
    end else if (is_mem(m_state) && !rdy) begin
      m_waits++;
    end else begin
      m_waits = 0;
      if (m_state == 0) begin
        load_path(op);
        m_state = m_path.pop_front();
      end else if (m_path.size() == 0) begin
        m_state = 0;
      end else begin
        m_state = m_path.pop_front();
      end
    end
  endtask

  logic [5:0] legal_ops[6];

  initial begin
    obs_t       got, exp;
    logic [13:0] dgot, dexp;
    logic        r;
    logic [5:0]  op;

    legal_ops[0] = R; legal_ops[1] = LW; legal_ops[2] = SW;
    legal_ops[3] = BEQ; legal_ops[4] = ADDI; legal_ops[5] = J;

    //             mreq iord memwr irrdy regdst mtr regwr srca srcb   aluop  pcsrc  pcwr br
    tab[0]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b1,1'b0};
    tab[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0,1'b0};
    tab[2]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0};
    tab[3]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0};
    tab[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0};
    tab[5]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0};
    tab[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00,1'b0,1'b0};
    tab[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0};
    tab[8]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b0,1'b1};
    tab[9]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0};
    tab[10] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0};
    tab[11] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,1'b1,1'b0};

    //   rst op  z rdy st mreq aluop regwr regdst mtr memwr pcen ill err
    add(1, R,   0, 1,  0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);  // held in reset
    add(0, R,   0, 1,  0, 1, 2'b00, 0, 0, 0, 0, 1, 0, 0);  // R-type
    add(0, R,   0, 1,  1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    add(0, R,   0, 1,  6, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0);
    add(0, R,   0, 1,  7, 0, 2'b00, 1, 1, 0, 0, 0, 0, 0);
    add(0, LW,  0, 1,  0, 1, 2'b00, 0, 0, 0, 0, 1, 0, 0);  // LW, 3 waits in MEMRD
    add(0, LW,  0, 1,  1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    add(0, LW,  0, 1,  2, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    add(0, LW,  0, 0,  3, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    add(0, LW,  0, 0,  3, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    add(0, LW,  0, 0,  3, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    add(0, LW,  0, 1,  3, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    add(0, LW,  0, 1,  4, 0, 2'b00, 1, 0, 1, 0, 0, 0, 0);
    add(0, BEQ, 0, 1,  0, 1, 2'b00, 0, 0, 0, 0, 1, 0, 0);  // BEQ taken
    add(0, BEQ, 1, 1,  1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    add(0, BEQ, 1, 1,  8, 0, 2'b01, 0, 0, 0, 0, 1, 0, 0);
    add(0, BEQ, 0, 1,  0, 1, 2'b00, 0, 0, 0, 0, 1, 0, 0);  // BEQ not taken
    add(0, BEQ, 0, 1,  1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    add(0, BEQ, 0, 1,  8, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0);
    add(0, BAD, 0, 1,  0, 1, 2'b00, 0, 0, 0, 0, 1, 0, 0);  // illegal opcode
    add(0, BAD, 0, 1,  1, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0);
    add(0, SW,  0, 0,  0, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0);  // SW, fetch wait then timeout
    add(0, SW,  0, 1,  0, 1, 2'b00, 0, 0, 0, 0, 1, 0, 0);
    add(0, SW,  0, 1,  1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    add(0, SW,  0, 1,  2, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    add(0, SW,  0, 0,  5, 1, 2'b00, 0, 0, 0, 1, 0, 0, 0);
    add(0, SW,  0, 0,  5, 1, 2'b00, 0, 0, 0, 1, 0, 0, 0);
    add(0, SW,  0, 0,  5, 1, 2'b00, 0, 0, 0, 1, 0, 0, 0);
    add(0, SW,  0, 0,  5, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    add(0, SW,  0, 1,  0, 1, 2'b00, 0, 0, 0, 0, 1, 0, 1);  // sticky error
    add(0, SW,  0, 1,  1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1);
    add(0, SW,  0, 1,  2, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1);
    add(1, SW,  0, 1,  5, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1);  // reset in MEMWR
    add(0, ADDI,0, 0,  0, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    add(0, ADDI,0, 1,  0, 1, 2'b00, 0, 0, 0, 0, 1, 0, 0);  // ADDI
    add(0, ADDI,0, 1,  1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    add(0, ADDI,0, 1,  9, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    add(0, ADDI,0, 1, 10, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0);
    add(0, J,   0, 1,  0, 1, 2'b00, 0, 0, 0, 0, 1, 0, 0);  // J
    add(0, J,   0, 1,  1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    add(0, J,   0, 1, 11, 0, 2'b00, 0, 0, 0, 0, 1, 0, 0);
    add(0, R,   0, 1,  0, 1, 2'b00, 0, 0, 0, 0, 1, 0, 0);

    // rst is high from time 0, so the first edge puts the FSM in FETCH.
    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      rst = vt[i].rst; Op = vt[i].op; Zero = vt[i].zero; Mem_Ready = vt[i].rdy;
      #1;
      dgot = {State, Mem_Req, ALU_Op, RegWrite, RegDst, MemtoReg, MemWrite, PCEn, Illegal_Op, Mem_Err};
      dexp = {vt[i].st, vt[i].mreq, vt[i].aluop, vt[i].regwr, vt[i].regdst, vt[i].mtr,
              vt[i].memwr, vt[i].pcen, vt[i].ill, vt[i].err};
      n_cmp++;
      if (dgot !== dexp) begin
        n_bad++;
        $display("FAIL vec%0d st/mreq/aluop/regwr/regdst/mtr/memwr/pcen/ill/err got %b expected %b",
                 i, dgot, dexp);
      end else begin
        $display("vec%0d op=%b state=%0d ok", i, vt[i].op, vt[i].st);
      end
    end

    // Randomized traffic against the model, starting from a clean reset.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    m_state = 0; m_waits = 0; m_err = 1'b0; m_path.delete();
    op = R;
    for (int c = 0; c < 1500; c++) begin
      r = ($urandom_range(0, 99) < 2);
      if (m_state == 0) begin
        if ($urandom_range(0, 9) == 0) op = 6'($urandom);
        else op = legal_ops[$urandom_range(0, 5)];
      end
      rst = r; Op = op; Zero = 1'($urandom); Mem_Ready = ($urandom_range(0, 99) < 55);
      #1;
      got = sample_obs();
      model_cycle(r, op, Zero, Mem_Ready, exp);
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL rnd%0d op=%b rst=%0d rdy=%0d zero=%0d outputs got %h expected %h",
                 c, op, r, Mem_Ready, Zero, got, exp);
      end else if (exp.st == 4'd1) begin
        $display("rnd%0d decode op=%b ok", c, op);
      end
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
